// File: rtl/pool_stream.sv
// pool_stream: streaming non-overlapping P x P pooling stage.
//
// Consumes a row-major WIDTH x WIDTH activation map, one pixel per channel
// on each ce beat, and emits one pooled pixel per channel for every complete
// P x P window. Max or average pooling is chosen per frame from pool_mode,
// which is captured on the first beat of the frame. Partial window results
// live in a per-column line buffer (one entry per output column), so no
// frame storage is needed. Pixels in trailing rows/columns that do not fill
// a whole window are consumed and dropped.
//
// Ports:
//   clk           rising-edge clock
//   global_rst_n  asynchronous active-low reset
//   ce            input beat qualifier
//   pool_mode     0 = max, 1 = average (sampled on the frame's first beat)
//   myInput       C packed signed pixels, channel c at [c*dataWidth +: dataWidth]
//   data_out      pooled pixels, same packing, held between strobes
//   valid_op      one-cycle strobe, data_out valid
//   end_op        one-cycle strobe with the last valid_op of a frame
module pool_stream #(
    parameter int dataWidth = 8,
    parameter int WIDTH     = 28,
    parameter int P         = 2,
    parameter int C         = 1
) (
    input  logic                   clk,
    input  logic                   global_rst_n,
    input  logic                   ce,
    input  logic                   pool_mode,
    input  logic [C*dataWidth-1:0] myInput,
    output logic [C*dataWidth-1:0] data_out,
    output logic                   valid_op,
    output logic                   end_op
);
    localparam int LG  = $clog2(P);
    localparam int AW  = dataWidth + 2 * LG;
    localparam int PO  = WIDTH / P;
    localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int CW1 = CW + 1;
    localparam int JW  = (PO > 1) ? $clog2(PO) : 1;

    localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
    localparam logic [CW:0]   REGION_END = CW1'(PO * P);
    localparam logic [LG-1:0] PHASE_LAST = {LG{1'b1}};
    localparam logic [JW-1:0] LAST_WIN   = JW'(PO - 1);

    logic [CW-1:0]         col_r;
    logic [CW-1:0]         row_r;
    logic                  mode_r;
    logic signed [AW-1:0]  acc_r [0:PO-1][0:C-1];

    logic                  in_region_s;
    logic                  start_s;
    logic                  complete_s;
    logic                  last_win_s;
    logic [JW-1:0]         j_s;
    logic signed [AW-1:0]  pix_s [0:C-1];
    logic signed [AW-1:0]  cmb_s [0:C-1];
    logic [dataWidth-1:0]  res_s [0:C-1];

    // Decode where the current beat falls relative to the pooling windows
    always_comb begin
        in_region_s = ({1'b0, col_r} < REGION_END) && ({1'b0, row_r} < REGION_END);
        if (in_region_s) begin
            j_s = JW'(col_r >> LG);
        end else begin
            // Out-of-region beats never touch the buffer; keep the index legal
            j_s = {JW{1'b0}};
        end
        start_s    = in_region_s && (col_r[LG-1:0] == {LG{1'b0}})
                                 && (row_r[LG-1:0] == {LG{1'b0}});
        complete_s = in_region_s && (col_r[LG-1:0] == PHASE_LAST)
                                 && (row_r[LG-1:0] == PHASE_LAST);
        last_win_s = (j_s == LAST_WIN) && (JW'(row_r >> LG) == LAST_WIN);
    end

    // Per-channel: widen the pixel, fold it into the window, scale the result
    always_comb begin
        for (int c = 0; c < C; c++) begin
            pix_s[c] = AW'($signed(myInput[c*dataWidth +: dataWidth]));
            if (mode_r) begin
                cmb_s[c] = acc_r[j_s][c] + pix_s[c];
            end else if (pix_s[c] > acc_r[j_s][c]) begin
                cmb_s[c] = pix_s[c];
            end else begin
                cmb_s[c] = acc_r[j_s][c];
            end
            // Arithmetic shift gives floor division of the window sum
            if (mode_r) begin
                res_s[c] = dataWidth'(cmb_s[c] >>> (2 * LG));
            end else begin
                res_s[c] = dataWidth'(cmb_s[c]);
            end
        end
    end

    // Raster position counters and per-frame mode capture
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            col_r  <= {CW{1'b0}};
            row_r  <= {CW{1'b0}};
            mode_r <= 1'b0;
        end else if (ce) begin
            if ((col_r == {CW{1'b0}}) && (row_r == {CW{1'b0}})) begin
                mode_r <= pool_mode;
            end
            if (col_r == LAST_IDX) begin
                col_r <= {CW{1'b0}};
                if (row_r == LAST_IDX) begin
                    row_r <= {CW{1'b0}};
                end else begin
                    row_r <= row_r + 1'b1;
                end
            end else begin
                col_r <= col_r + 1'b1;
            end
        end
    end

    // Line buffer of partial window results, one entry per output column
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int j = 0; j < PO; j++) begin
                for (int c = 0; c < C; c++) begin
                    acc_r[j][c] <= {AW{1'b0}};
                end
            end
        end else if (ce && in_region_s) begin
            for (int c = 0; c < C; c++) begin
                if (start_s) begin
                    acc_r[j_s][c] <= pix_s[c];
                end else begin
                    acc_r[j_s][c] <= cmb_s[c];
                end
            end
        end
    end

    // Output register and strobes, one cycle after the completing beat
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            data_out <= {(C*dataWidth){1'b0}};
            valid_op <= 1'b0;
            end_op   <= 1'b0;
        end else begin
            valid_op <= ce && complete_s;
            end_op   <= ce && complete_s && last_win_s;
            if (ce && complete_s) begin
                for (int c = 0; c < C; c++) begin
                    data_out[c*dataWidth +: dataWidth] <= res_s[c];
                end
            end
        end
    end

endmodule
